fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 158 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the combinational imem, registers each word with its PC for decode.
// Latency: instruction at pc appears on fetch_* one cycle after issue; 1 word/cycle while decode_ready=1.
// Backpressure: output stage holds while fetch_valid & !decode_ready; redirects squash it, faults freeze it.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] MEM_LIMIT = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic        fetch_valid,
  output logic [31:0] fetch_inst,
  output logic [31:0] fetch_pc,
  input  logic        decode_ready,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_type,
  input  logic [31:0] redirect_pc,
  input  logic [25:0] redirect_imm,
  input  logic [31:0] redirect_reg,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [1:0] RT_NONE   = 2'b00;
  localparam logic [1:0] RT_BRANCH = 2'b01;
  localparam logic [1:0] RT_JUMP   = 2'b10;
  localparam logic [1:0] RT_JR     = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] fpc_q, fpc_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] count_q, count_d;

  logic        accept;
  logic        redir;
  logic        can_issue;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] target;

  // Redirect target: branch is relative to the delay-slot PC, jump keeps its region bits.
  always_comb begin
    pc_plus4 = redirect_pc + 32'd4;
    br_off   = {{14{redirect_imm[15]}}, redirect_imm[15:0], 2'b00};
    target   = pc_q;
    case (redirect_type)
      RT_BRANCH: target = pc_plus4 + br_off;
      RT_JUMP:   target = {pc_plus4[31:28], redirect_imm, 2'b00};
      RT_JR:     target = redirect_reg;
      default:   target = pc_q;
    endcase
  end

  // Next-state and datapath: redirect first, then halt, then sequential issue.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    inst_d       = inst_q;
    fpc_d        = fpc_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    count_d      = count_q;

    accept    = valid_q & decode_ready;
    redir     = redirect_valid && (redirect_type != RT_NONE) && (state_q != FAULT);
    can_issue = !valid_q || accept;

    if (redir) begin
      // Squash the in-flight word; it never counts as accepted.
      valid_d = 1'b0;
      if (target[1:0] != 2'b00) begin
        state_d      = FAULT;
        fault_d      = 1'b1;
        fault_addr_d = target;
      end else begin
        pc_d = target;
      end
    end else begin
      if (accept) begin
        count_d = count_q + 32'd1;
        valid_d = 1'b0;
      end
      case (state_q)
        RUN: begin
          if (halt_req) begin
            if (can_issue) state_d = HALT;
          end else if (can_issue) begin
            if (pc_q >= MEM_LIMIT) begin
              state_d      = FAULT;
              fault_d      = 1'b1;
              fault_addr_d = pc_q;
              valid_d      = 1'b0;
            end else begin
              inst_d  = imem_inst;
              fpc_d   = pc_q;
              valid_d = 1'b1;
              pc_d    = pc_q + 32'd4;
            end
          end
        end
        HALT: begin
          if (!halt_req) state_d = RUN;
        end
        default: begin
          state_d = FAULT;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      inst_q       <= 32'd0;
      fpc_q        <= 32'd0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'd0;
      count_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      inst_q       <= inst_d;
      fpc_q        <= fpc_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      count_q      <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign fetch_valid = valid_q;
  assign fetch_inst  = inst_q;
  assign fetch_pc    = fpc_q;
  assign fault       = fault_q;
  assign fault_addr  = fault_addr_q;
  assign fetch_count = count_q;
  assign halted      = (state_q == HALT) && !valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        decode_ready;
  logic        redirect_valid;
  logic [1:0]  redirect_type;
  logic [31:0] redirect_pc;
  logic [25:0] redirect_imm;
  logic [31:0] redirect_reg;
  logic        halt_req;
  logic        halted;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .MEM_LIMIT(32'h0000_0080)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .fetch_valid   (fetch_valid),
    .fetch_inst    (fetch_inst),
    .fetch_pc      (fetch_pc),
    .decode_ready  (decode_ready),
    .redirect_valid(redirect_valid),
    .redirect_type (redirect_type),
    .redirect_pc   (redirect_pc),
    .redirect_imm  (redirect_imm),
    .redirect_reg  (redirect_reg),
    .halt_req      (halt_req),
    .halted        (halted),
    .fault         (fault),
    .fault_addr    (fault_addr),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: a few real MIPS words, a recognisable pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h80)       return 32'hDEAD_BEEF;
    else if (a == 32'd0)   return 32'h3409_0005;
    else if (a == 32'd4)   return 32'h340a_0005;
    else if (a == 32'd16)  return 32'h0149_6024;
    else                   return 32'h1000_0000 | a;
  endfunction

  always_comb imem_inst = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [1:0]  rt;
    logic [31:0] rpc;
    logic [25:0] rimm;
    logic [31:0] rreg;
    logic        halt;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic [31:0] e_count;
    logic        e_halted;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rdy, input logic rv, input logic [1:0] rt,
                     input logic [31:0] rpc, input logic [25:0] rimm, input logic [31:0] rreg,
                     input logic halt, input logic ev, input logic [31:0] epc,
                     input logic [31:0] eaddr, input logic [31:0] ecnt, input logic eh);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rt = rt; v.rpc = rpc; v.rimm = rimm; v.rreg = rreg;
    v.halt = halt; v.e_valid = ev; v.e_pc = epc; v.e_addr = eaddr; v.e_count = ecnt;
    v.e_halted = eh;
    vt.push_back(v);
  endtask

  // Plain sequential step with no redirect and no halt.
  task automatic seq(input logic rdy, input logic ev, input logic [31:0] epc,
                     input logic [31:0] eaddr, input logic [31:0] ecnt);
    add(rdy, 1'b0, 2'b00, 32'd0, 26'd0, 32'd0, 1'b0, ev, epc, eaddr, ecnt, 1'b0);
  endtask

  initial begin
    rst_n          = 1'b0;
    decode_ready   = 1'b0;
    redirect_valid = 1'b0;
    redirect_type  = 2'b00;
    redirect_pc    = 32'd0;
    redirect_imm   = 26'd0;
    redirect_reg   = 32'd0;
    halt_req       = 1'b0;

    // Sequential fetch and backpressure
    seq(1, 1, 0, 4, 0);
    seq(1, 1, 4, 8, 1);
    seq(1, 1, 8, 12, 2);
    seq(1, 1, 12, 16, 3);
    seq(1, 1, 16, 20, 4);
    seq(0, 1, 16, 20, 4);
    seq(0, 1, 16, 20, 4);
    seq(0, 1, 16, 20, 4);
    seq(1, 1, 20, 24, 5);
    seq(1, 1, 24, 28, 6);
    seq(1, 1, 28, 32, 7);
    seq(1, 1, 32, 36, 8);
    seq(1, 1, 36, 40, 9);
    seq(1, 1, 40, 44, 10);
    // Branch from 40, offset +2 words -> 52; in-flight word squashed and not counted
    add(1, 1, 2'b01, 32'd40, 26'h0002, 32'd0, 0, 0, 0, 52, 10, 0);
    seq(1, 1, 52, 56, 10);
    seq(1, 1, 56, 60, 11);
    // Jump from 56 with imm26=0x12 -> 72
    add(1, 1, 2'b10, 32'd56, 26'h12, 32'd0, 0, 0, 0, 72, 11, 0);
    seq(1, 1, 72, 76, 11);
    seq(1, 1, 76, 80, 12);
    // jr to 60
    add(1, 1, 2'b11, 32'd0, 26'd0, 32'd60, 0, 0, 0, 60, 12, 0);
    seq(1, 1, 60, 64, 12);
    // redirect_valid with type 00 is ignored
    add(1, 1, 2'b00, 32'd0, 26'd0, 32'd4, 0, 1, 64, 68, 13, 0);
    // Backward branch from 64, offset -2 words -> 60
    add(1, 1, 2'b01, 32'd64, 26'h000FFFE, 32'd0, 0, 0, 0, 60, 13, 0);
    seq(1, 1, 60, 64, 13);
    // Halt while output stalled: stays un-halted until the accept
    add(0, 0, 2'b00, 32'd0, 26'd0, 32'd0, 1, 1, 60, 64, 13, 0);
    add(0, 0, 2'b00, 32'd0, 26'd0, 32'd0, 1, 1, 60, 64, 13, 0);
    add(1, 0, 2'b00, 32'd0, 26'd0, 32'd0, 1, 0, 0, 64, 14, 1);
    add(1, 0, 2'b00, 32'd0, 26'd0, 32'd0, 1, 0, 0, 64, 14, 1);
    add(1, 0, 2'b00, 32'd0, 26'd0, 32'd0, 0, 0, 0, 64, 14, 0);
    seq(1, 1, 64, 68, 14);
    seq(1, 1, 68, 72, 15);

    // Reset state
    #12;
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_inst", fetch_inst, 32'd0);
    chk("rst_pc", fetch_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_fault_addr", fault_addr, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      decode_ready   = vt[i].rdy;
      redirect_valid = vt[i].rv;
      redirect_type  = vt[i].rt;
      redirect_pc    = vt[i].rpc;
      redirect_imm   = vt[i].rimm;
      redirect_reg   = vt[i].rreg;
      halt_req       = vt[i].halt;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, fetch_valid}, {31'd0, vt[i].e_valid});
      chk($sformatf("v%0d_addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("v%0d_count", i), fetch_count, vt[i].e_count);
      chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vt[i].e_halted});
      chk($sformatf("v%0d_fault", i), {31'd0, fault}, 32'd0);
      if (vt[i].e_valid) begin
        chk($sformatf("v%0d_pc", i), fetch_pc, vt[i].e_pc);
        chk($sformatf("v%0d_inst", i), fetch_inst, mem_word(vt[i].e_pc));
      end
    end
    redirect_valid = 1'b0;
    redirect_type  = 2'b00;
    halt_req       = 1'b0;
    decode_ready   = 1'b1;

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, fetch_valid}, 32'd0);
    chk("async_addr", imem_addr, 32'd0);
    chk("async_count", fetch_count, 32'd0);
    chk("async_pc", fetch_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_valid", {31'd0, fetch_valid}, 32'd1);
    chk("after_rst_pc", fetch_pc, 32'd0);
    @(posedge clk); #1;
    chk("after_rst_pc2", fetch_pc, 32'd4);

    // Misaligned jr target faults and freezes everything
    redirect_valid = 1'b1;
    redirect_type  = 2'b11;
    redirect_reg   = 32'h0000_0042;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    redirect_type  = 2'b00;
    chk("jr_fault", {31'd0, fault}, 32'd1);
    chk("jr_fault_addr", fault_addr, 32'h42);
    chk("jr_fault_valid", {31'd0, fetch_valid}, 32'd0);
    chk("jr_fault_addr_out", imem_addr, 32'd8);
    for (int k = 0; k < 3; k++) begin
      redirect_valid = 1'b1;
      redirect_type  = 2'b11;
      redirect_reg   = 32'h0000_0010;
      @(posedge clk); #1;
      chk($sformatf("frozen%0d_fault", k), {31'd0, fault}, 32'd1);
      chk($sformatf("frozen%0d_valid", k), {31'd0, fetch_valid}, 32'd0);
      chk($sformatf("frozen%0d_addr", k), imem_addr, 32'd8);
      chk($sformatf("frozen%0d_fault_addr", k), fault_addr, 32'h42);
    end
    redirect_valid = 1'b0;
    redirect_type  = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("fault_cleared", {31'd0, fault}, 32'd0);
    chk("fault_addr_cleared", fault_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Run off the end of memory: fault at MEM_LIMIT
    for (int k = 0; k < 40 && !fault; k++) begin
      @(posedge clk); #1;
    end
    chk("limit_fault", {31'd0, fault}, 32'd1);
    chk("limit_fault_addr", fault_addr, 32'h80);
    chk("limit_valid", {31'd0, fetch_valid}, 32'd0);
    chk("limit_last_pc", fetch_pc, 32'd124);
    chk("limit_count", fetch_count, 32'd32);
    chk("limit_addr", imem_addr, 32'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
